banked_mem_dump: RTL and testbench

- Sequential reader for the 6-bank, 64-bit state memory.
- Bank 0 holds 48 entries; banks 1..5 hold 24 entries each.
- Addressing uses the bank-encoded 9-bit format {bank[2:0], index[5:0]}.
- On start, walks every valid entry in ascending order (bank 0 through bank 5), drives the combinational read port, and streams each word out on a valid/ready interface with its address and a last flag.
- Sits beside the memory's write-side logic and serves debug dump and scrub traffic.

---
 rtl/banked_mem_dump.sv | 199 +++++++++++++++++++
 tb/tb_banked_mem_dump.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_dump.sv
// banked_mem_dump: sequential reader for the 6-bank, 64-bit state memory.
// Walks every valid entry (bank 0 with BANK0_DEPTH entries, banks 1..NBANKS-1
// with BANKN_DEPTH entries) in ascending order, reads each through the
// combinational read port and streams it out on a valid/ready interface.
// Used beside the write-side logic for debug dumps and scrub traffic.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           one-cycle request to begin a dump (ignored while busy)
//   abort           cancel the dump in progress (wins over start)
//   rd_addr         {bank, index} read address, driven from the pointer register
//   rd_data         read data for rd_addr, same cycle
//   out_valid/out_ready, out_data, out_addr, out_last   output stream
//   busy            high while a dump is running (RUN or LAST)
//   done            one-cycle pulse after the final handshake
//   sum             (only with BANKED_MEM_DUMP_SUM_EN) running fold of accepted words
//
// Optional feature macro: BANKED_MEM_DUMP_SUM_EN
module banked_mem_dump #(
    parameter int unsigned DW          = 64,
    parameter int unsigned AW          = 9,
    parameter int unsigned NBANKS      = 6,
    parameter int unsigned BANK0_DEPTH = 48,
    parameter int unsigned BANKN_DEPTH = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef BANKED_MEM_DUMP_SUM_EN
    ,
    output logic [DW-1:0] sum
`endif
);

    localparam int unsigned BW = 3;
    localparam int unsigned IW = $clog2(BANK0_DEPTH);

    localparam logic [IW-1:0] IDX_LAST0 = IW'(BANK0_DEPTH - 1);
    localparam logic [IW-1:0] IDX_LASTN = IW'(BANKN_DEPTH - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(NBANKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bank_q, bank_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          out_valid_d;
    logic [DW-1:0] out_data_d;
    logic [AW-1:0] out_addr_d;
    logic          out_last_d;
    logic          busy_d;
    logic          done_d;

    logic          load;
    logic          hs;
    logic          is_final;
    logic [IW-1:0] idx_last;

`ifdef BANKED_MEM_DUMP_SUM_EN
    logic [DW-1:0] sum_d;
`endif

    // Read address straight from the pointer register; index zero-padded to AW-BW bits.
    assign rd_addr = {bank_q, (AW - BW)'(idx_q)};

    assign load     = !out_valid || out_ready;
    assign hs       = out_valid && out_ready;
    assign idx_last = (bank_q == '0) ? IDX_LAST0 : IDX_LASTN;
    assign is_final = (bank_q == BANK_LAST) && (idx_q == IDX_LASTN);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        idx_d       = idx_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_addr_d  = out_addr;
        out_last_d  = out_last;
        done_d      = 1'b0;
`ifdef BANKED_MEM_DUMP_SUM_EN
        sum_d       = sum;
`endif

        if (abort) begin
            // Discard any pending beat; the pointer is kept until the next start.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bank_d  = '0;
                        idx_d   = '0;
                        state_d = S_RUN;
`ifdef BANKED_MEM_DUMP_SUM_EN
                        sum_d   = '0;
`endif
                    end
                end

                S_RUN: begin
                    if (load) begin
                        out_valid_d = 1'b1;
                        out_data_d  = rd_data;
                        out_addr_d  = rd_addr;
                        out_last_d  = is_final;
                        if (is_final) begin
                            // Pointer parks on the final entry; banks past NBANKS-1 are never addressed.
                            state_d = S_LAST;
                        end else if (idx_q == idx_last) begin
                            idx_d  = '0;
                            bank_d = bank_q + BW'(1);
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end

                S_LAST: begin
                    if (hs) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            endcase

`ifdef BANKED_MEM_DUMP_SUM_EN
            // Fold every accepted word; hs is never true in IDLE so this cannot collide with the clear.
            if (hs) begin
                sum_d = out_data ^ {sum[DW-2:0], sum[DW-1] ^ sum[2] ^ sum[0]};
            end
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bank_q    <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            idx_q     <= idx_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_addr  <= out_addr_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef BANKED_MEM_DUMP_SUM_EN
    // Running fold of accepted words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else begin
            sum <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_banked_mem_dump.sv
// Self-checking bench for banked_mem_dump: scoreboard of expected beats,
// handshake monitor with hold checks, directed scenarios in one initial block.
module tb_banked_mem_dump;

    typedef struct packed {
        logic [8:0]  addr;
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [8:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef BANKED_MEM_DUMP_SUM_EN
    logic [63:0] sum;
`endif

    banked_mem_dump dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef BANKED_MEM_DUMP_SUM_EN
        ,
        .sum       (sum)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    beat_t       sb[$];
    int          bcnt;
    int          done_cnt;
    logic [8:0]  beat_addr [0:167];
    logic [63:0] mem [0:511];
    logic        mem_mode = 1'b0;
    logic        lfsr_mode = 1'b0;
    logic        ready_force = 1'b1;
    logic [63:0] lfsr = 64'h5aef0c8d_d70a4497;
    logic        abort_at_edge = 1'b0;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_data;
    logic [8:0]  hold_addr;
    logic        hold_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read.
    always_comb begin
        rd_data = mem_mode ? mem[rd_addr] : {55'd0, rd_addr};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] beat_to_addr(input int k);
        int b;
        int i;
        if (k < 48) begin
            b = 0;
            i = k;
        end else begin
            b = 1 + (k - 48) / 24;
            i = (k - 48) % 24;
        end
        return {3'(b), 6'(i)};
    endfunction

    function automatic logic [63:0] exp_data(input logic [8:0] a);
        return mem_mode ? mem[a] : {55'd0, a};
    endfunction

    task automatic push_beats(input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.addr = beat_to_addr(k);
            b.data = exp_data(b.addr);
            b.last = (k == 167);
            sb.push_back(b);
        end
    endtask

    // Edge-side: record abort as the DUT sees it, then drive ready away from the edge.
    always @(posedge clk) begin
        abort_at_edge = abort;
        #2;
        if (lfsr_mode) begin
            lfsr = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
            out_ready = lfsr[0];
        end else begin
            out_ready = ready_force;
        end
    end

    // Monitor: hold checks, handshake scoreboard, done counting.
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && !abort_at_edge) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, hold_data);
                check("hold_addr", 64'(out_addr), 64'(hold_addr));
                check("hold_last", 64'(out_last), 64'(hold_last));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_addr = out_addr;
            hold_last = out_last;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(sb.size()), 64'd1);
                end else begin
                    b = sb.pop_front();
                    check("beat_addr", 64'(out_addr), 64'(b.addr));
                    check("beat_data", out_data, b.data);
                    check("beat_last", 64'(out_last), 64'(b.last));
                end
                if (bcnt < 168) beat_addr[bcnt] = out_addr;
                bcnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < budget);
    endtask

    task automatic wait_beats(input int target);
        int guard;
        guard = 0;
        while (bcnt < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_beats_reached", 64'(bcnt >= target), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_out_addr"}, 64'(out_addr), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic run_clean(input string tag, input int budget);
        int n;
        bcnt = 0;
        done_cnt = 0;
        push_beats(168);
        pulse_start();
        wait_done(budget, n);
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_beats"}, 64'(bcnt), 64'd168);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int n;
        int guard;
        logic [63:0] c;
        logic [63:0] s;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        c = 64'h0123_4567_89ab_cdef;
        for (int a = 0; a < 512; a++) begin
            for (int j = 0; j < 8; j++) begin
                c = {c[62:0], 1'b0} ^ (c[63] ? 64'h42F0E1EBA9EA3693 : 64'd0);
            end
            mem[a] = c;
        end

        // Reset state.
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Full dump, no stall, done latency.
        bcnt = 0;
        done_cnt = 0;
        push_beats(168);
        pulse_start();
        wait_done(400, n);
        check("full_done_latency", 64'(n), 64'd169);
        check("full_done_seen", 64'(done), 64'd1);
        check("full_beats", 64'(bcnt), 64'd168);
        check("full_sb_empty", 64'(sb.size()), 64'd0);
        check("full_beat0", 64'(beat_addr[0]), 64'h000);
        check("full_beat47", 64'(beat_addr[47]), 64'h02F);
        check("full_beat48", 64'(beat_addr[48]), 64'h040);
        check("full_beat72", 64'(beat_addr[72]), 64'h080);
        check("full_beat167", 64'(beat_addr[167]), 64'h157);
        @(posedge clk);
        #1;
        check("full_done_one_cycle", 64'(done), 64'd0);
        check("full_busy_after", 64'(busy), 64'd0);

        // Backpressure on the LFSR pattern.
        lfsr_mode = 1'b1;
        run_clean("bp", 3000);
        lfsr_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Abort on beat 50.
        bcnt = 0;
        done_cnt = 0;
        push_beats(51);
        pulse_start();
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(out_valid && out_addr == 9'h042) && guard < 500);
        check("abort_found_beat50", 64'(out_addr), 64'h042);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_last", 64'(out_last), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_beats", 64'(bcnt), 64'd51);
        check("abort_sb_empty", 64'(sb.size()), 64'd0);
        run_clean("restart", 400);
        check("restart_beat0", 64'(beat_addr[0]), 64'h000);

        // Start pulses during a running dump are ignored.
        bcnt = 0;
        done_cnt = 0;
        push_beats(168);
        pulse_start();
        wait_beats(10);
        pulse_start();
        wait_beats(100);
        pulse_start();
        wait_done(400, n);
        check("restart_ign_done", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("restart_ign_beats", 64'(bcnt), 64'd168);
        check("restart_ign_sb_empty", 64'(sb.size()), 64'd0);
        check("restart_ign_done_pulses", 64'(done_cnt), 64'd1);
        check("restart_ign_busy", 64'(busy), 64'd0);

        // start + abort together in IDLE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges around beat 80.
        bcnt = 0;
        done_cnt = 0;
        push_beats(168);
        pulse_start();
        wait_beats(80);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("async_rst_no_done", 64'(done_cnt), 64'd0);
        run_clean("post_rst", 400);

`ifdef BANKED_MEM_DUMP_SUM_EN
        // Fold over a CRC-driven memory image.
        mem_mode = 1'b1;
        s = 64'd0;
        for (int k = 0; k < 168; k++) begin
            s = mem[beat_to_addr(k)] ^ {s[62:0], s[63] ^ s[2] ^ s[0]};
        end
        run_clean("sum", 400);
        check("sum_after_done", sum, s);

        // Aborted dump after the first accepted beat: sum holds the one-word fold.
        push_beats(168);
        pulse_start();
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 50);
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        ready_force = 1'b1;
        check("sum_abort_first", sum, mem[0]);
        repeat (5) @(posedge clk);
        #1;
        check("sum_abort_hold", sum, mem[0]);
        check("sum_abort_busy", 64'(busy), 64'd0);
        sb.delete();
        mem_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
